// File: rtl/onehot_tally_if.sv
// Bus between a one-hot decoder monitor and whatever drives/observes it.
// The monitor side takes the slave modport; the stimulus/host side takes master.
interface onehot_tally_if #(
  parameter int CW = 8
);
  logic [3:0]    D;
  logic          sample;
  logic          clear;
  logic [1:0]    rd_sel;
  logic [CW-1:0] rd_count;
  logic [1:0]    last_A;
  logic          valid_out;
  logic          onehot_err;
  logic [CW-1:0] err_count;
  logic          all_seen;
  logic          sat;

  modport master (
    output D, sample, clear, rd_sel,
    input  rd_count, last_A, valid_out, onehot_err, err_count, all_seen, sat
  );

  modport slave (
    input  D, sample, clear, rd_sel,
    output rd_count, last_A, valid_out, onehot_err, err_count, all_seen, sat
  );
endinterface

// File: rtl/onehot_tally.sv
// Monitor for a 2-to-4 one-hot decoder: checks each strobed word is one-hot,
// tallies hits per line (saturating), re-encodes the active line and flags errors.
module onehot_tally #(
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  onehot_tally_if.slave   bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    seen_q, seen_d;
  logic [1:0]    last_a_q, last_a_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          all_seen_q, all_seen_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] rd_count_q, rd_count_d;

  logic          legal;
  logic [1:0]    idx;

  // Legal means exactly one bit set; the case doubles as the 4-to-2 encoder.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    legal = 1'b1;
    idx   = 2'd0;
    case (bus.D)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    last_a_d   = last_a_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    sat_d      = sat_q;
    all_seen_d = &seen_q;
    rd_count_d = cnt_q[bus.rd_sel];

    if (bus.clear) begin
      // Clear wins over a same-cycle sample; rd_count still reloads from the old counters.
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
      seen_d     = '0;
      last_a_d   = '0;
      err_d      = 1'b0;
      err_cnt_d  = '0;
      sat_d      = 1'b0;
      all_seen_d = 1'b0;
    end else if (bus.sample) begin
      if (legal) begin
        if (cnt_q[idx] != CNT_MAX) cnt_d[idx] = cnt_q[idx] + 1'b1;
        if (cnt_d[idx] == CNT_MAX) sat_d = 1'b1;
        last_a_d    = idx;
        seen_d[idx] = 1'b1;
        valid_d     = 1'b1;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is only four words and must read zero out of reset, so every entry is reset.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      seen_q     <= '0;
      last_a_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      all_seen_q <= 1'b0;
      sat_q      <= 1'b0;
      rd_count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      seen_q     <= seen_d;
      last_a_q   <= last_a_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      all_seen_q <= all_seen_d;
      sat_q      <= sat_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign bus.rd_count   = rd_count_q;
  assign bus.last_A     = last_a_q;
  assign bus.valid_out  = valid_q;
  assign bus.onehot_err = err_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.all_seen   = all_seen_q;
  assign bus.sat        = sat_q;

endmodule
